// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver with its own 16x oversampling tick generator.
// Deserialises rx (LSB first, 7 or 8 data bits, optional odd/even parity,
// 1 or 2 stop bits) and presents each character on a held register with a
// valid/ack handshake plus parity, frame, overrun and alarm flags.
//
// Ports:
//   clkdiv      system clock
//   reset       synchronous, active-high
//   rx          serial input, idle high, asynchronous to clkdiv
//   enable      receiver enable; deassertion aborts a frame on the next tick
//   bd_rate     selects DIV0..DIV3 clkdiv cycles per 16x tick
//   par         00/11 none, 01 odd, 10 even
//   d_num       0 = 7 data bits, 1 = 8 data bits
//   s_num       0 = 1 stop bit, 1 = 2 stop bits
//   rd_ack      consumer acknowledges data_out
//   data_out    last received character
//   data_ready  high while data_out is unread
//   data_valid  one-cycle pulse per completed frame
//   parity_err  parity error for the current data_out
//   frame_err   stop-bit error for the current data_out
//   overrun     sticky, set when unread data is overwritten
//   alarm_sig   one-cycle pulse with data_valid when character == ALARM_CODE
//   busy        high when not idle
module uart_rx_ctrl #(
  parameter int unsigned DIV0       = 2604,
  parameter int unsigned DIV1       = 1302,
  parameter int unsigned DIV2       = 12,
  parameter int unsigned DIV3       = 326,
  parameter logic [7:0]  ALARM_CODE = 8'd250
) (
  input  logic       clkdiv,
  input  logic       reset,
  input  logic       rx,
  input  logic       enable,
  input  logic [1:0] bd_rate,
  input  logic [1:0] par,
  input  logic       d_num,
  input  logic       s_num,
  input  logic       rd_ack,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       alarm_sig,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic        rx_meta_q, rxs_q;
  logic [11:0] tc_q, tc_d, div_m1;
  logic        tick;

  state_t      state_q, state_d;
  logic [3:0]  sc_q, sc_d;
  logic [2:0]  bi_q, bi_d;
  logic [7:0]  shift_q, shift_d;
  logic        perr_q, perr_d, ferr_q, ferr_d;
  logic        arm_q, arm_d;
  logic [1:0]  par_l_q, par_l_d;
  logic        dnum_l_q, dnum_l_d, snum_l_q, snum_l_d;
  logic        fin, ones_odd;

  logic [7:0]  data_out_q;
  logic        data_ready_q, data_valid_q, perr_out_q, ferr_out_q;
  logic        overrun_q, alarm_q;

  always_comb begin
    case (bd_rate)
      2'b00:   div_m1 = 12'(DIV0 - 32'd1);
      2'b01:   div_m1 = 12'(DIV1 - 32'd1);
      2'b10:   div_m1 = 12'(DIV2 - 32'd1);
      default: div_m1 = 12'(DIV3 - 32'd1);
    endcase
  end

  // >= rather than == so a smaller divisor selected mid-count wraps at once
  assign tick = (tc_q >= div_m1);
  assign tc_d = tick ? '0 : tc_q + 12'd1;

  always_ff @(posedge clkdiv) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      tc_q      <= '0;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      tc_q      <= tc_d;
    end
  end

  always_ff @(posedge clkdiv) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sc_q     <= '0;
      bi_q     <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      arm_q    <= 1'b1;
      par_l_q  <= '0;
      dnum_l_q <= 1'b0;
      snum_l_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      bi_q     <= bi_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      arm_q    <= arm_d;
      par_l_q  <= par_l_d;
      dnum_l_q <= dnum_l_d;
      snum_l_q <= snum_l_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bi_d     = bi_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    arm_d    = arm_q;
    par_l_d  = par_l_q;
    dnum_l_d = dnum_l_q;
    snum_l_d = snum_l_q;
    fin      = 1'b0;
    ones_odd = (^shift_q) ^ rxs_q;
    if (tick) begin
      if (state_q == S_IDLE) begin
        // arm_q blocks restarting on a held-low (break) line until it is seen high
        if (rxs_q) begin
          arm_d = 1'b1;
        end else if (enable && arm_q) begin
          state_d  = S_START;
          sc_d     = '0;
          par_l_d  = par;
          dnum_l_d = d_num;
          snum_l_d = s_num;
        end
      end else if (!enable) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_START: begin
            if (sc_q == 4'd7) begin
              if (rxs_q) begin
                state_d = S_IDLE;
              end else begin
                state_d = S_DATA;
                sc_d    = '0;
                bi_d    = '0;
                shift_d = '0;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
              end
            end else begin
              sc_d = sc_q + 4'd1;
            end
          end
          S_DATA: begin
            if (sc_q == 4'd15) begin
              shift_d[bi_q] = rxs_q;
              sc_d          = '0;
              if (bi_q == {2'b11, dnum_l_q}) begin
                bi_d    = '0;
                state_d = (par_l_q == 2'b01 || par_l_q == 2'b10) ? S_PARITY : S_STOP;
              end else begin
                bi_d = bi_q + 3'd1;
              end
            end else begin
              sc_d = sc_q + 4'd1;
            end
          end
          S_PARITY: begin
            if (sc_q == 4'd15) begin
              perr_d  = (par_l_q == 2'b01) ? !ones_odd : ones_odd;
              sc_d    = '0;
              state_d = S_STOP;
            end else begin
              sc_d = sc_q + 4'd1;
            end
          end
          S_STOP: begin
            if (sc_q == 4'd15) begin
              if (!rxs_q) ferr_d = 1'b1;
              sc_d = '0;
              // bi_q doubles as the stop-bit index here
              if (snum_l_q && bi_q == 3'd0) begin
                bi_d = 3'd1;
              end else begin
                state_d = S_IDLE;
                fin     = 1'b1;
                if (!rxs_q) arm_d = 1'b0;
              end
            end else begin
              sc_d = sc_q + 4'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Outputs load at the final stop-sample edge, so they appear the cycle after it
  always_ff @(posedge clkdiv) begin
    if (reset) begin
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      data_valid_q <= 1'b0;
      perr_out_q   <= 1'b0;
      ferr_out_q   <= 1'b0;
      overrun_q    <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      data_valid_q <= fin;
      alarm_q      <= fin && (shift_q == ALARM_CODE);
      if (fin) begin
        data_out_q   <= shift_q;
        perr_out_q   <= perr_d;
        ferr_out_q   <= ferr_d;
        data_ready_q <= 1'b1;
        if (data_ready_q && !rd_ack) overrun_q <= 1'b1;
      end else if (rd_ack && data_ready_q) begin
        data_ready_q <= 1'b0;
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;
  assign data_valid = data_valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign overrun    = overrun_q;
  assign alarm_sig  = alarm_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at bd_rate=10 (12 clk/tick, 192 clk/bit).
module tb_uart_rx_ctrl;
  localparam int unsigned BIT = 192;

  logic       clkdiv = 1'b0;
  logic       reset, rx, enable, d_num, s_num, rd_ack;
  logic [1:0] bd_rate, par;
  logic [7:0] data_out;
  logic       data_ready, data_valid, parity_err, frame_err, overrun, alarm_sig, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cnt = 0;
  int alarm_cnt = 0;
  int alarm_with_valid = 0;

  uart_rx_ctrl #(.DIV0(2604), .DIV1(1302), .DIV2(12), .DIV3(326), .ALARM_CODE(8'd250)) dut (
    .clkdiv(clkdiv), .reset(reset), .rx(rx), .enable(enable), .bd_rate(bd_rate),
    .par(par), .d_num(d_num), .s_num(s_num), .rd_ack(rd_ack), .data_out(data_out),
    .data_ready(data_ready), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .alarm_sig(alarm_sig), .busy(busy)
  );

  always #5 clkdiv = ~clkdiv;

  always @(negedge clkdiv) begin
    if (data_valid) valid_cnt++;
    if (alarm_sig) alarm_cnt++;
    if (alarm_sig && data_valid) alarm_with_valid++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clkdiv);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    cycles(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input int unsigned nbits, input bit use_par,
                            input logic pbit, input logic stop2, input bit two_stop);
    drive_bit(1'b0);
    for (int unsigned i = 0; i < nbits; i++) drive_bit(d[i]);
    if (use_par) drive_bit(pbit);
    drive_bit(1'b1);
    if (two_stop) drive_bit(stop2);
    rx = 1'b1;
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    cycles(1);
    rd_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; enable = 1'b1; bd_rate = 2'b10; par = 2'b00;
    d_num = 1'b1; s_num = 1'b0; rd_ack = 1'b0;
    cycles(5);
    reset = 1'b0;
    cycles(2);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_ready", 32'(data_ready), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_alarm", 32'(alarm_sig), 0);
    chk("rst_busy", 32'(busy), 0);

    // 0xA5 8N1
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    cycles(20);
    chk("a5_valid_cnt", 32'(valid_cnt), 1);
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_ready", 32'(data_ready), 1);
    chk("a5_perr", 32'(parity_err), 0);
    chk("a5_ferr", 32'(frame_err), 0);
    ack();
    chk("a5_ack_ready", 32'(data_ready), 0);

    // even parity, wrong then right parity bit
    par = 2'b10;
    send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    cycles(20);
    chk("5a_bad_data", 32'(data_out), 32'h5A);
    chk("5a_bad_perr", 32'(parity_err), 1);
    ack();
    send_frame(8'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    cycles(20);
    chk("5a_good_data", 32'(data_out), 32'h5A);
    chk("5a_good_perr", 32'(parity_err), 0);
    chk("5a_valid_cnt", 32'(valid_cnt), 3);
    chk("5a_overrun", 32'(overrun), 0);
    ack();

    // 7O2, second stop bit low
    d_num = 1'b0; par = 2'b01; s_num = 1'b1;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b0, 1'b1);
    cycles(20);
    chk("41_data", 32'(data_out), 32'h41);
    chk("41_ferr", 32'(frame_err), 1);
    chk("41_perr", 32'(parity_err), 0);
    ack();

    // false start: 60 clk low
    rx = 1'b0;
    cycles(60);
    rx = 1'b1;
    cycles(300);
    chk("fs_busy", 32'(busy), 0);
    chk("fs_valid_cnt", 32'(valid_cnt), 4);
    chk("fs_data", 32'(data_out), 32'h41);
    chk("fs_ferr", 32'(frame_err), 1);
    chk("fs_ready", 32'(data_ready), 0);

    // back-to-back without ack: overrun and alarm
    d_num = 1'b1; par = 2'b00; s_num = 1'b0;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFA, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    cycles(20);
    chk("b2b_valid_cnt", 32'(valid_cnt), 6);
    chk("b2b_data", 32'(data_out), 32'hFA);
    chk("b2b_overrun", 32'(overrun), 1);
    chk("b2b_ready", 32'(data_ready), 1);
    chk("b2b_alarm_cnt", 32'(alarm_cnt), 1);
    chk("b2b_alarm_with_valid", 32'(alarm_with_valid), 1);

    // reset mid-DATA
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b1; rx = 1'b1;
    cycles(4);
    reset = 1'b0;
    cycles(1);
    chk("mrst_data", 32'(data_out), 32'h00);
    chk("mrst_ready", 32'(data_ready), 0);
    chk("mrst_overrun", 32'(overrun), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ferr", 32'(frame_err), 0);
    cycles(BIT);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    cycles(20);
    chk("3c_data", 32'(data_out), 32'h3C);
    chk("3c_ready", 32'(data_ready), 1);
    chk("3c_perr", 32'(parity_err), 0);
    chk("3c_ferr", 32'(frame_err), 0);
    chk("3c_valid_cnt", 32'(valid_cnt), 7);
    ack();

    // enable dropped mid-frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("en_busy_before", 32'(busy), 1);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    cycles(50);
    chk("en_busy_after", 32'(busy), 0);
    chk("en_valid_cnt", 32'(valid_cnt), 7);
    chk("en_data", 32'(data_out), 32'h3C);
    chk("en_ready", 32'(data_ready), 0);
    enable = 1'b1;
    cycles(300);
    chk("end_busy", 32'(busy), 0);
    chk("end_alarm_cnt", 32'(alarm_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side counterpart of the UART controller/transmitter path. It generates its own 16x oversampling tick from `clkdiv` using the same four baud selections, deserialises the `rx` line, and checks parity and stop bits. Each received character is presented on a held output register with a valid/ack handshake, plus error, overrun and alarm flags.

Parameters:
DIV0, 2604, clkdiv cycles per 16x tick when bd_rate=00
DIV1, 1302, clkdiv cycles per 16x tick when bd_rate=01
DIV2, 12, clkdiv cycles per 16x tick when bd_rate=10
DIV3, 326, clkdiv cycles per 16x tick when bd_rate=11
ALARM_CODE, 8'd250, received character that raises alarm_sig

Ports:
clkdiv  in  1  system clock
reset  in  1  synchronous, active-high
rx  in  1  serial input, idle high, asynchronous to clkdiv
enable  in  1  receiver enable
bd_rate  in  2  baud select, indexes DIV0..DIV3
par  in  2  00 none, 01 odd, 10 even, 11 none
d_num  in  1  0 = 7 data bits, 1 = 8 data bits
s_num  in  1  0 = 1 stop bit, 1 = 2 stop bits
rd_ack  in  1  consumer acknowledges data_out
data_out  out  8  last received character, LSB first on line; bit7 = 0 in 7-bit mode
data_ready  out  1  high while data_out is unread
data_valid  out  1  one-cycle pulse per completed frame
parity_err  out  1  parity error flag for the current data_out
frame_err  out  1  stop-bit error flag for the current data_out
overrun  out  1  sticky; set when a frame completes while data_ready=1 and rd_ack=0
alarm_sig  out  1  one-cycle pulse, coincident with data_valid, when character == ALARM_CODE
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, synchronous, active-high:
  - All outputs go to 0.
  - Tick counter, bit counter and state (IDLE) are cleared.
  - Synchroniser flops are set to 1.
  - Reset dominates every other input.
- rx synchroniser: two flops. All decisions use rxs, the second-flop output.
- Tick generator (12-bit counter):
  - Counter increments every clkdiv cycle.
  - When counter >= DIVsel-1: tick=1 for one cycle and the counter returns to 0.
  - The `>=` compare means a bd_rate change never hangs the generator; it takes effect immediately.
  - The counter free-runs in all states.
- Configuration (bd_rate excluded, par, d_num, s_num) is latched at start detection and held for the whole frame.
- FSM, all transitions on tick cycles only; `sc` is a 4-bit tick counter:
  - IDLE:
    - If enable=1 and rxs=0 → START, sc=0.
  - START:
    - Advance to sc=7 (mid start bit).
    - At mid start bit, if rxs=1 → IDLE (false start, no flags).
    - Otherwise → DATA with sc=0 and bit index=0.
  - DATA:
    - Sample rxs when sc=15 (every 16 ticks) into shift position bit index.
    - After 7 or 8 bits → PARITY if the latched par is 01 or 10, otherwise → STOP.
  - PARITY:
    - Sample at sc=15.
    - Odd parity: error if ones(data)+parity bit is even.
    - Even parity: error if that sum is odd.
  - STOP:
    - Sample at sc=15; any 0 sample sets the frame error.
    - With s_num=1, a second stop bit is sampled 16 ticks later.
    - After the final stop sample → IDLE.
- Completion, in the cycle after the final stop sample:
  - data_out is loaded; bits not received are 0.
  - parity_err and frame_err are loaded.
  - data_valid pulses; alarm_sig pulses if applicable.
  - data_ready is set.
  - A line low on the first tick after the return to IDLE starts a new frame; there are no idle-gap requirements.
- Handshake:
  - rd_ack=1 while data_ready=1 clears data_ready on the next cycle. rd_ack has no effect when data_ready=0.
  - If completion and rd_ack occur in the same cycle: new data is loaded and data_ready stays 1; overrun is not set.
  - If completion occurs with data_ready=1 and rd_ack=0: data_out is overwritten with the new data and overrun is set. overrun is cleared only by reset.
- enable deasserted mid-frame: the next tick aborts to IDLE. No data_valid, and no change to data_out or the flags.
- Frame error with rx held low (break): after completion the FSM waits in IDLE. It does not start a new frame until rxs has been seen high on at least one tick.

Test Plan:
- Reset; bd_rate=10 (192 clk/bit), par=00, d_num=1, s_num=0; send 0xA5 8N1 → one data_valid, data_out=0xA5, data_ready=1, parity_err=0, frame_err=0; rd_ack → data_ready=0.
- par=10 (even); send 0x5A with parity bit 1 (wrong) → data_out=0x5A, parity_err=1. Repeat with parity bit 0 → parity_err=0.
- d_num=0, par=01 (odd), s_num=1; send 0x41 (7 bits), parity bit 1, two stop bits with the second stop bit = 0 → data_out=0x41, frame_err=1, parity_err=0.
- rx low for 5 ticks (60 clk) then high → busy returns 0, no data_valid, all flags unchanged.
- Two back-to-back frames 0x11 then 0xFA without rd_ack → data_out=0xFA, overrun=1, alarm_sig pulses with the second data_valid.
- Assert reset mid-DATA; after release send 0x3C → all outputs 0 after reset, then a clean reception of 0x3C. Also deassert enable mid-frame → no data_valid.
